// File: rtl/vga_sprite_pkg.sv
// Shared definitions for the sprite engine: register map offsets, flag bits,
// active-area limits and the per-slot register record.
package vga_sprite_pkg;

    localparam int HACTIVE = 1280;
    localparam int VACTIVE = 480;

    localparam logic [2:0] OFS_X_LO  = 3'd0;
    localparam logic [2:0] OFS_X_HI  = 3'd1;
    localparam logic [2:0] OFS_Y_LO  = 3'd2;
    localparam logic [2:0] OFS_Y_HI  = 3'd3;
    localparam logic [2:0] OFS_FRAME = 3'd4;
    localparam logic [2:0] OFS_FLAGS = 3'd5;

    localparam int CTRL_OFS   = 0;
    localparam int STATUS_OFS = 1;
    localparam int COLL_OFS   = 2;

    localparam int FLAG_EN     = 0;
    localparam int FLAG_FLIP_H = 1;
    localparam int FLAG_FLIP_V = 2;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic [7:0]  frame;
        logic [2:0]  flags;
    } slot_regs_t;

    function automatic logic is_vblank_edge(input logic [10:0] h, input logic [9:0] v);
        return (h == 11'd0) && (v == 10'(VACTIVE));
    endfunction

endpackage

// File: rtl/vga_sprite_engine_if.sv
// Avalon-MM slave register port of the sprite engine.
interface vga_sprite_engine_if #(
    parameter int ADDR_W = 7
);
    logic              chipselect;
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [7:0]        writedata;
    logic [7:0]        readdata;

    modport master (
        output chipselect, write, read, address, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, write, read, address, writedata,
        output readdata
    );
endinterface

// File: rtl/vga_sprite_engine_hit.sv
// Per-slot bounding-box test against the current pixel, plus the texel
// coordinates inside the sprite after optional mirroring.
module sprite_hit_unit #(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16,
    localparam int XW = $clog2(SPRITE_W),
    localparam int YW = $clog2(SPRITE_H)
) (
    input  logic [9:0]    px,
    input  logic [9:0]    py,
    input  logic [10:0]   x,
    input  logic [9:0]    y,
    input  logic          enable,
    input  logic          flip_h,
    input  logic          flip_v,
    output logic          hit,
    output logic [XW-1:0] rel_x,
    output logic [YW-1:0] rel_y
);

    logic signed [12:0] dx;
    logic signed [12:0] dy;

    always_comb begin
        // Signed differences wide enough that a sprite parked near x=2047 never aliases onto px 0..
        dx  = $signed({3'b000, px}) - $signed({2'b00, x});
        dy  = $signed({3'b000, py}) - $signed({3'b000, y});
        hit = enable && !dx[12] && (dx < 13'(SPRITE_W)) &&
              !dy[12] && (dy < 13'(SPRITE_H));
        rel_x = flip_h ? XW'(SPRITE_W - 1) - dx[XW-1:0] : dx[XW-1:0];
        rel_y = flip_v ? YW'(SPRITE_H - 1) - dy[YW-1:0] : dy[YW-1:0];
    end

endmodule

// File: rtl/vga_sprite_engine.sv
// Hardware sprite overlay: double-buffered slot registers committed at vblank,
// priority pixel selection with a 2-cycle ROM lookup pipeline, collision flags.
module vga_sprite_engine
    import vga_sprite_pkg::*;
#(
    parameter int          NUM_SPRITES = 8,
    parameter int          SPRITE_W    = 16,
    parameter int          SPRITE_H    = 16,
    parameter int          NUM_FRAMES  = 16,
    parameter logic [23:0] TRANSPARENT = 24'h000000,
    localparam int         ADDR_W      = $clog2(8*NUM_SPRITES+8),
    localparam int         ROM_AW      = $clog2(NUM_FRAMES*SPRITE_W*SPRITE_H)
) (
    input  logic                clk,
    input  logic                reset,
    vga_sprite_engine_if.slave  bus,
    input  logic [10:0]         hcount,
    input  logic [9:0]          vcount,
    output logic [ROM_AW-1:0]   rom_address,
    input  logic [23:0]         rom_data,
    output logic [23:0]         sprite_rgb,
    output logic                sprite_on
);

    localparam int XW    = $clog2(SPRITE_W);
    localparam int YW    = $clog2(SPRITE_H);
    localparam int CBASE = 8*NUM_SPRITES;
    localparam int NCOLL = NUM_SPRITES/8;

    slot_regs_t shadow [NUM_SPRITES];
    slot_regs_t active [NUM_SPRITES];
    logic       commit_pending;

    logic [NUM_SPRITES-1:0] coll_work;
    logic [NUM_SPRITES-1:0] coll_latched;

    logic              vblank_edge;
    logic              wr_en;
    logic              in_slots;
    logic              ctrl_set;
    logic [ADDR_W-4:0] slot_idx;
    logic [2:0]        reg_k;
    logic [7:0]        rd_mux;

    assign vblank_edge = is_vblank_edge(hcount, vcount);
    assign wr_en       = bus.chipselect && bus.write;
    assign in_slots    = bus.address < ADDR_W'(CBASE);
    assign slot_idx    = bus.address[ADDR_W-1:3];
    assign reg_k       = bus.address[2:0];
    assign ctrl_set    = wr_en && (bus.address == ADDR_W'(CBASE + CTRL_OFS)) && bus.writedata[0];

    // Register file: bus writes land in shadow only; active follows at a committed vblank edge.
    // Nonblocking semantics give active the pre-write shadow when a write meets a commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SPRITES; s++) begin
                shadow[s] <= '0;
                active[s] <= '0;
            end
            commit_pending <= 1'b0;
        end else begin
            if (vblank_edge && commit_pending) begin
                for (int s = 0; s < NUM_SPRITES; s++) begin
                    active[s] <= shadow[s];
                end
            end
            if (ctrl_set) begin
                commit_pending <= 1'b1;
            end else if (vblank_edge) begin
                commit_pending <= 1'b0;
            end
            if (wr_en && in_slots) begin
                for (int s = 0; s < NUM_SPRITES; s++) begin
                    if (slot_idx == (ADDR_W-3)'(s)) begin
                        case (reg_k)
                            OFS_X_LO:  shadow[s].x[7:0]  <= bus.writedata;
                            OFS_X_HI:  shadow[s].x[10:8] <= bus.writedata[2:0];
                            OFS_Y_LO:  shadow[s].y[7:0]  <= bus.writedata;
                            OFS_Y_HI:  shadow[s].y[9:8]  <= bus.writedata[1:0];
                            OFS_FRAME: shadow[s].frame   <= bus.writedata;
                            OFS_FLAGS: shadow[s].flags   <= bus.writedata[2:0];
                            default:   ;
                        endcase
                    end
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (in_slots) begin
            for (int s = 0; s < NUM_SPRITES; s++) begin
                if (slot_idx == (ADDR_W-3)'(s)) begin
                    case (reg_k)
                        OFS_X_LO:  rd_mux = shadow[s].x[7:0];
                        OFS_X_HI:  rd_mux = {5'b0, shadow[s].x[10:8]};
                        OFS_Y_LO:  rd_mux = shadow[s].y[7:0];
                        OFS_Y_HI:  rd_mux = {6'b0, shadow[s].y[9:8]};
                        OFS_FRAME: rd_mux = shadow[s].frame;
                        OFS_FLAGS: rd_mux = {5'b0, shadow[s].flags};
                        default:   rd_mux = '0;
                    endcase
                end
            end
        end else if (bus.address == ADDR_W'(CBASE + STATUS_OFS)) begin
            rd_mux = {7'b0, commit_pending};
        end else begin
            for (int j = 0; j < NCOLL; j++) begin
                if (bus.address == ADDR_W'(CBASE + COLL_OFS + j)) begin
                    rd_mux = coll_latched[8*j +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.readdata <= '0;
        end else if (bus.read && bus.chipselect) begin
            bus.readdata <= rd_mux;
        end
    end

    // ---- stage 1: register the incoming beam position ----
    logic [9:0] px_p1;
    logic [9:0] py_p1;
    logic       vld_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px_p1  <= '0;
            py_p1  <= '0;
            vld_p1 <= 1'b0;
        end else begin
            px_p1  <= hcount[10:1];
            py_p1  <= vcount;
            vld_p1 <= (hcount < 11'(HACTIVE)) && (vcount < 10'(VACTIVE));
        end
    end

    logic [NUM_SPRITES-1:0] hit;
    logic [XW-1:0]          rel_x [NUM_SPRITES];
    logic [YW-1:0]          rel_y [NUM_SPRITES];

    for (genvar s = 0; s < NUM_SPRITES; s++) begin : g_hit
        sprite_hit_unit #(
            .SPRITE_W (SPRITE_W),
            .SPRITE_H (SPRITE_H)
        ) u_hit (
            .px     (px_p1),
            .py     (py_p1),
            .x      (active[s].x),
            .y      (active[s].y),
            .enable (active[s].flags[FLAG_EN]),
            .flip_h (active[s].flags[FLAG_FLIP_H]),
            .flip_v (active[s].flags[FLAG_FLIP_V]),
            .hit    (hit[s]),
            .rel_x  (rel_x[s]),
            .rel_y  (rel_y[s])
        );
    end

    // ---- stage 2: priority select, ROM address presented for the output cycle ----
    logic              sel_any;
    logic [ROM_AW-1:0] sel_addr;
    logic              multi_hit;

    always_comb begin
        sel_addr = '0;
        // Walk downwards so the lowest-index covering slot is the one left standing.
        for (int s = NUM_SPRITES - 1; s >= 0; s--) begin
            if (hit[s]) begin
                sel_addr = ROM_AW'({active[s].frame, rel_y[s], rel_x[s]});
            end
        end
        sel_any     = vld_p1 && (hit != '0);
        rom_address = sel_any ? sel_addr : '0;
        multi_hit   = (hit & (hit - NUM_SPRITES'(1))) != '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coll_work    <= '0;
            coll_latched <= '0;
        end else if (vblank_edge) begin
            coll_latched <= coll_work;
            coll_work    <= '0;
        end else if (vld_p1 && multi_hit) begin
            coll_work <= coll_work | hit;
        end
    end

    logic vld_p2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= sel_any;
        end
    end

    // ---- output: ROM texel arrives this cycle; key colour reads as no sprite ----
    always_comb begin
        sprite_on  = vld_p2 && (rom_data != TRANSPARENT);
        sprite_rgb = sprite_on ? rom_data : 24'h000000;
    end

endmodule

// File: doc/vga_sprite_engine.md
VGA_SPRITE_ENGINE -- requirements
Module: vga_sprite_engine

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 8: sprite slots, 1..32, multiple of 8.
REQ-002 SHALL have parameter SPRITE_W / SPRITE_H, defaults 16 / 16: sprite size in pixels, powers of 2.
REQ-003 SHALL have parameter NUM_FRAMES, default 16: images held in sprite ROM.
REQ-004 SHALL have parameter TRANSPARENT, default 24'h000000: RGB key treated as see-through.
REQ-005 SHALL have derived ADDR_W = clog2(8*NUM_SPRITES+8) and ROM_AW = clog2(NUM_FRAMES*SPRITE_W*SPRITE_H).
REQ-006 SHALL have port clk  in  1  system clock, 50 MHz.
REQ-007 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports chipselect, write, read  in  1 each  Avalon-MM slave strobes.
REQ-009 SHALL have ports address  in  ADDR_W;  writedata  in  8;  readdata  out  8.
REQ-010 SHALL have ports hcount  in  11 and vcount  in  10  from the VGA timing generator; pixel x = hcount[10:1].
REQ-011 SHALL have ports rom_address  out  ROM_AW and rom_data  in  24  for a synchronous ROM, 1-cycle read latency.
REQ-012 SHALL have ports sprite_rgb  out  24  and sprite_on  out  1  for the pixel mux.

Function
REQ-013 SHALL map slot s at address 8*s+k, k = 0 x[7:0], 1 x[10:8], 2 y[7:0], 3 y[9:8], 4 frame index, 5 flags (bit0 enable, bit1 flip_h, bit2 flip_v), 6-7 reserved (write ignored, read 0).
REQ-014 SHALL map the control block at C = 8*NUM_SPRITES: C+0 CTRL (write bit0=1 sets commit_pending), C+1 STATUS (read bit0 = commit_pending), C+2.. collision bytes, one bit per slot, read-only.
REQ-015 SHALL write only shadow registers via the bus; displayed (active) registers change only at commit.
REQ-016 SHALL commit at the vblank edge (hcount==0 && vcount==480): if commit_pending, copy all shadow to active and clear commit_pending in that cycle.
REQ-017 SHALL, when a CTRL commit write coincides with the vblank edge, leave commit_pending set and defer the copy to the next frame.
REQ-018 SHALL, when a shadow write coincides with a commit, give active the pre-write shadow value and shadow the new value.
REQ-019 SHALL return readdata registered one cycle after read&&chipselect; shadow values for slot registers.
REQ-020 SHALL treat slot s as covering pixel (px,py) iff enabled && x<=px<x+SPRITE_W && y<=py<y+SPRITE_H, compared at 12 bits so no wrap at x near 2047.
REQ-021 SHALL select the lowest-index covering slot when visible (hcount<1280 && vcount<480); transparent texels do not fall through to higher-index slots.
REQ-022 SHALL compute rel_x = px-x, inverted to SPRITE_W-1-rel_x if flip_h (rel_y likewise with flip_v), and rom_address = frame*SPRITE_W*SPRITE_H + rel_y*SPRITE_W + rel_x; frame >= NUM_FRAMES wraps modulo 2^(ROM_AW-log2(W*H)).
REQ-023 SHALL have fixed latency 2 cycles from hcount/vcount to sprite_rgb/sprite_on: stage 1 registers coordinates, stage 2 selects and drives rom_address, ROM returns data in the output cycle.
REQ-024 SHALL drive sprite_on=1 only if a slot was selected and rom_data != TRANSPARENT; otherwise sprite_on=0 and sprite_rgb=0.
REQ-025 SHALL set a working collision bit for every slot that covers a visible pixel covered by >=2 enabled slots (bounding-box test).
REQ-026 SHALL latch the working collision bits into the readable collision bytes at the vblank edge and clear working bits in the same cycle.

Reset
REQ-027 SHALL on reset clear all shadow and active registers (all slots disabled, x=y=frame=flags=0), commit_pending, collision bits, pipeline registers, readdata, rom_address, sprite_rgb and sprite_on.
REQ-028 SHALL, if reset asserts mid-frame, force sprite_on=0 immediately and resume normal output 2 cycles after release, with no commit until the next vblank edge.

Structure
REQ-029 SHALL place register offsets, flag bit positions, HACTIVE=1280, VACTIVE=480 and the slot register record typedef in package vga_sprite_pkg.
REQ-030 SHALL use one sub-module, sprite_hit_unit (per-slot coverage test and flipped rel_x/rel_y), instantiated NUM_SPRITES times.

Verification
REQ-031 SHALL cover: slot 0 x=100 y=50 enable, commit, ROM texel 24'hFF0000 -> sprite_on=1, rgb FF0000 at hcount=200 vcount=50 two cycles later; 0 at hcount=232 (px 116).
REQ-032 SHALL cover: slots 0 and 1 overlapping at (300,100) -> slot 0 colour shown; after vblank edge, collision byte reads 8'h03; slot 2 alone reads 0.
REQ-033 SHALL cover: shadow x write without commit -> display unchanged across 2 frames; set CTRL bit0 -> STATUS bit0=1 until vblank edge, then 0 and new x displayed.
REQ-034 SHALL cover: flip_h on slot 0 at x=100 -> px 100 requests rel_x=15 (rom_address = frame*256+rel_y*16+15).
REQ-035 SHALL cover: CTRL write on the exact vblank-edge cycle -> no copy that frame, copy at next edge.
REQ-036 SHALL cover: x=2040, width 16 -> no wrap hit at px 0..7; reset mid-line -> sprite_on=0 and all registers cleared.
